// File: rtl/ds2431_io_arbiter.sv
// ds2431_io_arbiter
// Shares the single 1-Wire byte-transfer engine between the function-command
// modules. Each requester posts one byte at a time into its own slot. The
// arbiter picks a winner, issues it to the engine and routes the completion
// back to that winner only. A 1-Wire bus reset drops all outstanding work.
// Optional feature: define VDS2431_IO_ARB_RR_EN for round-robin selection.
// When it is undefined, selection is fixed priority and the lowest index wins.
module ds2431_io_arbiter #(
    parameter int N_REQ = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               busRst,
    input  logic [N_REQ-1:0]   req_trig,
    input  logic [N_REQ-1:0]   req_nRxTx,
    input  logic [8*N_REQ-1:0] req_sentDat,
    output logic [N_REQ-1:0]   req_done,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   overrun,
    output logic               busy,
    output logic               io_trig,
    output logic               io_nRxTx,
    output logic [7:0]         io_sentDat,
    input  logic               io_done,
    input  logic [7:0]         io_receiveDat,
    output logic [7:0]         rxDat
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;

    logic [N_REQ-1:0]        pending_q, pending_d;
    logic [N_REQ-1:0]        dir_q;
    logic [N_REQ-1:0][7:0]   dat_q;
    logic [N_REQ-1:0]        overrun_q;

    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [N_REQ-1:0]        reqDone_q, reqDone_d;
    logic                    ioTrig_q, ioTrig_d;
    logic                    ioDir_q, ioDir_d;
    logic [7:0]              ioDat_q, ioDat_d;
    logic [7:0]              rxDat_q, rxDat_d;
    logic                    busy_q, busy_d;

    logic                    doneAccept;
    logic [N_REQ-1:0]        clrSlot;
    logic [N_REQ-1:0]        capture;
    logic [N_REQ-1:0]        ovSet;
    logic [IDX_W-1:0]        selIdx;
    logic                    selFound;

    // A completion only counts while waiting on the engine and never against a bus reset
    assign doneAccept = (state_q == WAIT) && io_done && !busRst;
    assign clrSlot    = doneAccept ? grant_q : '0;

    // Slot bookkeeping: a freshly cleared slot may be refilled in the same cycle
    always_comb begin
        capture   = '0;
        ovSet     = '0;
        pending_d = '0;
        if (!busRst) begin
            capture   = req_trig & (~pending_q | clrSlot);
            ovSet     = req_trig & pending_q & ~clrSlot;
            pending_d = (pending_q & ~clrSlot) | capture;
        end
    end

    // Slot storage and the sticky overrun flags, which only rst clears
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            dir_q     <= '0;
            dat_q     <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_q | ovSet;
            for (int i = 0; i < N_REQ; i++) begin
                if (capture[i]) begin
                    dir_q[i] <= req_nRxTx[i];
                    dat_q[i] <= req_sentDat[8*i +: 8];
                end
            end
        end
    end

`ifdef VDS2431_IO_ARB_RR_EN
    logic [IDX_W-1:0] rrPtr_q;
    logic [IDX_W-1:0] winIdx_q;
    int               rrIdx;

    // Round-robin search starting at the slot after the previous winner
    always_comb begin
        selIdx   = '0;
        selFound = 1'b0;
        rrIdx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            rrIdx = int'(rrPtr_q) + k;
            if (rrIdx >= N_REQ) begin
                rrIdx = rrIdx - N_REQ;
            end
            if (!selFound && pending_q[rrIdx]) begin
                selIdx   = IDX_W'(rrIdx);
                selFound = 1'b1;
            end
        end
    end

    // Remember the winner and advance the pointer when its transfer completes
    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_q  <= '0;
            winIdx_q <= '0;
        end else begin
            if (state_q == IDLE && selFound && !busRst) begin
                winIdx_q <= selIdx;
            end
            if (doneAccept) begin
                rrPtr_q <= (winIdx_q == IDX_W'(N_REQ - 1)) ? '0 : winIdx_q + 1'b1;
            end
        end
    end
`else
    // Fixed priority: the lowest pending index wins
    always_comb begin
        selIdx   = '0;
        selFound = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!selFound && pending_q[k]) begin
                selIdx   = IDX_W'(k);
                selFound = 1'b1;
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a bus reset always returns to IDLE
    always_comb begin
        state_d = state_q;
        if (busRst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (selFound) state_d = ISSUE;
                ISSUE:   state_d = WAIT;
                WAIT:    if (io_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        grant_d   = grant_q;
        reqDone_d = '0;
        ioTrig_d  = 1'b0;
        ioDir_d   = ioDir_q;
        ioDat_d   = ioDat_q;
        rxDat_d   = rxDat_q;
        busy_d    = (state_d != IDLE);
        if (busRst) begin
            grant_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (selFound) begin
                        grant_d  = N_REQ'(1) << selIdx;
                        ioTrig_d = 1'b1;
                        ioDir_d  = dir_q[selIdx];
                        ioDat_d  = dat_q[selIdx];
                    end
                end
                WAIT: begin
                    if (io_done) begin
                        rxDat_d   = io_receiveDat;
                        reqDone_d = grant_q;
                        grant_d   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q   <= '0;
            reqDone_q <= '0;
            ioTrig_q  <= 1'b0;
            ioDir_q   <= 1'b0;
            ioDat_q   <= '0;
            rxDat_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            reqDone_q <= reqDone_d;
            ioTrig_q  <= ioTrig_d;
            ioDir_q   <= ioDir_d;
            ioDat_q   <= ioDat_d;
            rxDat_q   <= rxDat_d;
            busy_q    <= busy_d;
        end
    end

    assign req_done   = reqDone_q;
    assign grant      = grant_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
    assign io_trig    = ioTrig_q;
    assign io_nRxTx   = ioDir_q;
    assign io_sentDat = ioDat_q;
    assign rxDat      = rxDat_q;

endmodule

// File: tb/tb_ds2431_io_arbiter.sv
// tb_ds2431_io_arbiter
// Directed bench for ds2431_io_arbiter: single transfer, simultaneous
// requests, overrun, bus reset, stray completion and mid-transfer reset.
// Define VDS2431_IO_ARB_RR_EN for both bench and design to check round-robin order.
module tb_ds2431_io_arbiter;

    localparam int N = 6;

    logic           clk;
    logic           rst;
    logic           busRst;
    logic [N-1:0]   req_trig;
    logic [N-1:0]   req_nRxTx;
    logic [8*N-1:0] req_sentDat;
    logic [N-1:0]   req_done;
    logic [N-1:0]   grant;
    logic [N-1:0]   overrun;
    logic           busy;
    logic           io_trig;
    logic           io_nRxTx;
    logic [7:0]     io_sentDat;
    logic           io_done;
    logic [7:0]     io_receiveDat;
    logic [7:0]     rxDat;

    int             checks;
    int             failures;
    logic [7:0]     lastRx;

    ds2431_io_arbiter #(.N_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .busRst        (busRst),
        .req_trig      (req_trig),
        .req_nRxTx     (req_nRxTx),
        .req_sentDat   (req_sentDat),
        .req_done      (req_done),
        .grant         (grant),
        .overrun       (overrun),
        .busy          (busy),
        .io_trig       (io_trig),
        .io_nRxTx      (io_nRxTx),
        .io_sentDat    (io_sentDat),
        .io_done       (io_done),
        .io_receiveDat (io_receiveDat),
        .rxDat         (rxDat)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, required %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8*N-1:0] byteAt(input int idx, input logic [7:0] b);
        return (8*N)'(b) << (8 * idx);
    endfunction

    // Drive a set of requests for exactly one cycle
    task automatic applyStimulus(input logic [N-1:0] mask, input logic [N-1:0] dirs, input logic [8*N-1:0] data);
        req_trig    = mask;
        req_nRxTx   = dirs;
        req_sentDat = data;
        tick();
        req_trig    = '0;
        req_nRxTx   = '0;
        req_sentDat = '0;
    endtask

    task automatic waitTrig();
        for (int n = 0; n < 8 && io_trig !== 1'b1; n++) tick();
        checkOutput("io_trig_seen", 48'(io_trig), 48'd1);
    endtask

    // Serve one transfer end to end and check the routing of its completion
    task automatic runTransfer(input int idx, input logic dir, input logic [7:0] txb, input logic [7:0] rxb);
        logic [N-1:0] oh;
        oh = N'(1) << idx;
        waitTrig();
        checkOutput($sformatf("grant_%0d", idx), 48'(grant), 48'(oh));
        checkOutput($sformatf("sentDat_%0d", idx), 48'(io_sentDat), 48'(txb));
        checkOutput($sformatf("nRxTx_%0d", idx), 48'(io_nRxTx), 48'(dir));
        checkOutput("busy_issue", 48'(busy), 48'd1);
        tick();
        checkOutput("trig_one_cycle", 48'(io_trig), 48'd0);
        checkOutput("grant_wait", 48'(grant), 48'(oh));
        checkOutput("sentDat_wait", 48'(io_sentDat), 48'(txb));
        io_done       = 1'b1;
        io_receiveDat = rxb;
        tick();
        io_done       = 1'b0;
        io_receiveDat = 8'h00;
        checkOutput($sformatf("req_done_%0d", idx), 48'(req_done), 48'(oh));
        checkOutput("rxDat_latched", 48'(rxDat), 48'(rxb));
        checkOutput("grant_cleared", 48'(grant), 48'd0);
        checkOutput("busy_idle", 48'(busy), 48'd0);
        checkOutput("no_trig_after_done", 48'(io_trig), 48'd0);
        lastRx = rxb;
        tick();
        checkOutput("req_done_pulse", 48'(req_done), 48'd0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        lastRx        = 8'h00;
        rst           = 1'b1;
        busRst        = 1'b0;
        req_trig      = '0;
        req_nRxTx     = '0;
        req_sentDat   = '0;
        io_done       = 1'b0;
        io_receiveDat = 8'h00;
        tick();
        tick();

        // Reset state
        checkOutput("rst_grant",   48'(grant), 48'd0);
        checkOutput("rst_busy",    48'(busy), 48'd0);
        checkOutput("rst_trig",    48'(io_trig), 48'd0);
        checkOutput("rst_overrun", 48'(overrun), 48'd0);
        checkOutput("rst_rxDat",   48'(rxDat), 48'd0);
        checkOutput("rst_done",    48'(req_done), 48'd0);
        checkOutput("rst_sentDat", 48'(io_sentDat), 48'd0);
        rst = 1'b0;
        tick();

        // Single request on slot 2 with exact cycle timing
        applyStimulus(6'b000100, 6'b000100, byteAt(2, 8'hA5));
        checkOutput("c1_trig", 48'(io_trig), 48'd0);
        checkOutput("c1_busy", 48'(busy), 48'd0);
        tick();
        checkOutput("c2_trig", 48'(io_trig), 48'd1);
        runTransfer(2, 1'b1, 8'hA5, 8'h3C);

        // Make slot 3 the most recent winner, then post 1 and 4 together
        applyStimulus(6'b001000, 6'b000000, byteAt(3, 8'h11));
        runTransfer(3, 1'b0, 8'h11, 8'h22);
        applyStimulus(6'b010010, 6'b000010, byteAt(1, 8'h81) | byteAt(4, 8'h44));
`ifdef VDS2431_IO_ARB_RR_EN
        runTransfer(4, 1'b0, 8'h44, 8'h04);
        runTransfer(1, 1'b1, 8'h81, 8'h01);
`else
        runTransfer(1, 1'b1, 8'h81, 8'h01);
        runTransfer(4, 1'b0, 8'h44, 8'h04);
`endif

        // Retrigger of slot 0 in the same cycle as its completion is accepted
        applyStimulus(6'b000001, 6'b000000, byteAt(0, 8'h77));
        waitTrig();
        checkOutput("retrig_first_byte", 48'(io_sentDat), 48'h77);
        tick();
        io_done       = 1'b1;
        io_receiveDat = 8'h21;
        req_trig      = 6'b000001;
        req_nRxTx     = 6'b000001;
        req_sentDat   = byteAt(0, 8'hC3);
        tick();
        io_done       = 1'b0;
        io_receiveDat = 8'h00;
        req_trig      = '0;
        req_nRxTx     = '0;
        req_sentDat   = '0;
        checkOutput("retrig_done", 48'(req_done), 48'h1);
        checkOutput("retrig_rxDat", 48'(rxDat), 48'h21);
        checkOutput("retrig_no_overrun", 48'(overrun), 48'h0);
        runTransfer(0, 1'b1, 8'hC3, 8'h5E);

        // Second trigger while slot 0 is pending sets overrun and is dropped
        applyStimulus(6'b000001, 6'b000001, byteAt(0, 8'h5A));
        applyStimulus(6'b000001, 6'b000000, byteAt(0, 8'h99));
        checkOutput("overrun_set", 48'(overrun), 48'h1);
        runTransfer(0, 1'b1, 8'h5A, 8'h6B);
        tick();
        checkOutput("overrun_no_extra_trig", 48'(io_trig), 48'd0);
        checkOutput("overrun_sticky", 48'(overrun), 48'h1);

        // Bus reset during WAIT with three slots pending
        applyStimulus(6'b101100, 6'b101100, byteAt(2, 8'h02) | byteAt(3, 8'h03) | byteAt(5, 8'h05));
        waitTrig();
        checkOutput("busrst_winner", 48'(grant), 48'h04);
        tick();
        busRst = 1'b1;
        tick();
        busRst = 1'b0;
        checkOutput("busrst_grant", 48'(grant), 48'd0);
        checkOutput("busrst_busy", 48'(busy), 48'd0);
        checkOutput("busrst_trig", 48'(io_trig), 48'd0);
        checkOutput("busrst_done", 48'(req_done), 48'd0);
        checkOutput("busrst_overrun_kept", 48'(overrun), 48'h1);
        io_done       = 1'b1;
        io_receiveDat = 8'hD7;
        tick();
        io_done       = 1'b0;
        io_receiveDat = 8'h00;
        for (int n = 0; n < 4; n++) begin
            checkOutput("busrst_quiet", 48'({req_done, io_trig, busy}), 48'd0);
            tick();
        end
        checkOutput("busrst_rxDat_kept", 48'(rxDat), 48'(lastRx));

        // Bus reset in the same cycle as a request drops the request
        busRst = 1'b1;
        applyStimulus(6'b000010, 6'b000010, byteAt(1, 8'hB1));
        busRst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            checkOutput("busrst_drop_req", 48'({io_trig, busy, grant}), 48'd0);
            tick();
        end

        // Stray completion while idle
        io_done       = 1'b1;
        io_receiveDat = 8'hEE;
        tick();
        io_done       = 1'b0;
        io_receiveDat = 8'h00;
        checkOutput("stray_done", 48'(req_done), 48'd0);
        checkOutput("stray_rxDat", 48'(rxDat), 48'(lastRx));

        // Synchronous reset in the middle of a transfer
        applyStimulus(6'b010000, 6'b010000, byteAt(4, 8'h42));
        waitTrig();
        tick();
        checkOutput("pre_rst_busy", 48'(busy), 48'd1);
        rst = 1'b1;
        tick();
        checkOutput("midrst_outputs", 48'({req_done, grant, overrun, busy, io_trig, io_nRxTx}), 48'd0);
        checkOutput("midrst_bytes", 48'({io_sentDat, rxDat}), 48'd0);
        rst = 1'b0;
        tick();
        tick();
        checkOutput("midrst_no_trig", 48'(io_trig), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ds2431_io_arbiter.md
# ds2431_io_arbiter

Shares the single 1-Wire byte-transfer engine between the function-command modules (ReadRom, MatchRom, ReadMemory, WriteScratchpad, ReadScratchpad, CopyScratchpad). Each requester posts one byte transfer at a time. The arbiter latches the request, grants the engine to one requester, and drives the engine's trigger, direction and transmit byte. It routes the engine's completion back to that requester only. It replaces the ad-hoc trigger/direction/data muxing in the top-level command sequencer, and a 1-Wire bus reset aborts it cleanly.

## Interface
Parameters:
- `N_REQ`, 6: number of requesters; index 0 is highest priority in fixed-priority mode.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `busRst`  in  1: 1-Wire reset detected by the IO engine (sync, active-high). Aborts all work.
- `req_trig`  in  N_REQ: one-cycle pulse per requester; posts one byte transfer.
- `req_nRxTx`  in  N_REQ: direction, sampled with `req_trig`; 0 = receive, 1 = transmit.
- `req_sentDat`  in  8*N_REQ: byte to transmit, sampled with `req_trig`. Requester i uses bits [8i+7:8i].
- `req_done`  out  N_REQ: one-cycle pulse to the requester whose transfer completed.
- `grant`  out  N_REQ: one-hot; identifies the requester that owns the engine. All zero when idle.
- `overrun`  out  N_REQ: sticky; set when `req_trig` arrives while that requester is already pending.
- `busy`  out  1: high in any state other than IDLE.
- `io_trig`  out  1: one-cycle start pulse to the IO engine.
- `io_nRxTx`  out  1: direction to the IO engine.
- `io_sentDat`  out  8: transmit byte to the IO engine.
- `io_done`  in  1: one-cycle completion pulse from the IO engine.
- `io_receiveDat`  in  8: received byte from the IO engine, valid with `io_done`.
- `rxDat`  out  8: `io_receiveDat` latched on the `io_done` that was accepted; held until the next accepted `io_done`.

## Operation
- Per-requester slot: `pending`, a captured direction bit, and a captured 8-bit byte.
- `req_trig[i]` with `pending[i]` = 0: set `pending[i]` and capture direction and byte.
- `req_trig[i]` with `pending[i]` = 1: the request is ignored and `overrun[i]` is set.
  - Exception: if the same cycle also clears slot i (done for i), set wins and the new data is captured.
- FSM states:
  - IDLE: if any `pending` is set, select a winner, load the one-hot `grant`, and go to ISSUE.
  - ISSUE: `io_trig` = 1 for exactly one cycle; `io_nRxTx` and `io_sentDat` come from the winner's slot. Go to WAIT.
  - WAIT: hold `grant`, `io_nRxTx` and `io_sentDat` stable. On `io_done`: latch `rxDat`, clear the winner's `pending`, pulse `req_done[winner]` on the next cycle, clear `grant`, and go to IDLE.
- `io_done` outside WAIT is ignored: no pulse and no `rxDat` update.
- `busRst`, in any state: clear all `pending` and `grant`, go to IDLE, and force `io_trig` = 0.
  - No `req_done` is issued; `overrun` and `rxDat` are unchanged.
  - If `busRst` coincides with `io_done` or `req_trig`, `busRst` wins: no `req_done`, and the request is dropped.
- Reset values: all outputs 0, state IDLE, all slots cleared, round-robin pointer at 0.
- `overrun` bits clear only on `rst`.

## Timing
- `req_trig[i]` at cycle 0 sets `pending` visible at cycle 1. When the engine is idle, the winner is chosen at cycle 1, and `io_trig` and `grant` are high at cycle 2.
- `io_done` at cycle k gives `req_done` high and state IDLE at cycle k+1. The next `io_trig` comes no earlier than cycle k+2.
- All outputs are registered.
- `io_nRxTx` and `io_sentDat` are valid from the ISSUE cycle through the cycle of the accepted `io_done`.

## Configuration
- `VDS2431_IO_ARB_RR_EN`
  - Defined: round-robin. The search starts at the index after the last winner and wraps from N_REQ-1 to 0. The pointer updates on each accepted `io_done` and is untouched by `busRst`.
  - Undefined: fixed priority, lowest index wins.

## Test plan
- Single request: `req_trig[2]` with tx, byte 0xA5 -> `io_trig` at cycle 2 with `io_sentDat` = 0xA5 and `io_nRxTx` = 1, `grant` = 6'b000100. `io_done` with `io_receiveDat` = 0x3C -> `req_done[2]` one cycle later and `rxDat` = 0x3C.
- Simultaneous: `req_trig[1]` and `req_trig[4]` in the same cycle.
  - Fixed mode: 1 is served, then 4.
  - RR mode after a previous winner of 3: 4 is served, then 1.
- Overrun: a second `req_trig[0]` while slot 0 is pending -> `overrun[0]` = 1 and the original byte is transmitted. A retrigger on the same cycle as slot 0's `io_done` is accepted with no overrun.
- Bus reset: `busRst` during WAIT with 3 slots pending -> IDLE next cycle, `grant` = 0, no `req_done` ever. A later `io_done` is ignored.
- Stray `io_done` in IDLE -> no `req_done` and `rxDat` unchanged. `rst` mid-WAIT -> all outputs 0 next cycle.
